// File: rtl/ssd_scan_scheduler_pkg.sv
// Shared constants and types for the seven-segment scan scheduler.
// Holds the FSM encoding, display geometry and frame bundle layout.
package ssd_scan_scheduler_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int PWM_SLICES = 16;
    localparam int DEF_DWELL_CYCLES = 100000;
    localparam int DEF_BLANK_CYCLES = 2000;

    localparam logic [7:0] ANODES_OFF = 8'hFF;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BLANK = 2'd1;
    localparam logic [1:0] ST_SHOW  = 2'd2;

    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  dp;
        logic [7:0]  mask;
    } frame_t;

    function automatic logic [3:0] nibble_at(
        input logic [31:0] d,
        input logic [2:0]  i
    );
        return d[{i, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/ssd_frame_buffer.sv
// Double-buffered frame store: shadow written over valid/ready,
// copied to the active frame only at frame boundaries or while idle.
module ssd_frame_buffer
    import ssd_scan_scheduler_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_valid,
    input  logic [31:0] wr_data,
    input  logic [7:0]  wr_dp,
    input  logic [7:0]  wr_mask,
    input  logic        swap_en,
    output logic        wr_ready,
    output frame_t      active
);

    frame_t shadow;
    logic   pending;
    logic   accept;

    assign wr_ready = ~pending;
    assign accept   = wr_valid & ~pending;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow      <= '0;
            active.data <= '0;
            active.dp   <= '0;
            active.mask <= 8'hFF;
            pending     <= 1'b0;
        end else if (pending && swap_en) begin
            active  <= shadow;
            pending <= 1'b0;
        end else if (accept) begin
            shadow.data <= wr_data;
            shadow.dp   <= wr_dp;
            shadow.mask <= wr_mask;
            pending     <= 1'b1;
        end
    end

endmodule

// File: rtl/ssd_scan_scheduler.sv
// Eight-digit multiplexed display scanner with blanking gap,
// 16-level PWM brightness and a double-buffered frame.
module ssd_scan_scheduler
    import ssd_scan_scheduler_pkg::*;
#(
    parameter int DWELL_CYCLES = DEF_DWELL_CYCLES,
    parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [3:0]  brightness,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [31:0] wr_data,
    input  logic [7:0]  wr_dp,
    input  logic [7:0]  wr_mask,
    output logic [7:0]  an,
    output logic [3:0]  digit_code,
    output logic        dp_out,
    output logic [2:0]  digit_sel,
    output logic        frame_done
);

    localparam int SLICE_CYCLES = DWELL_CYCLES / PWM_SLICES;
    localparam int CNT_MAX = (SLICE_CYCLES > BLANK_CYCLES) ?
                             SLICE_CYCLES : BLANK_CYCLES;
    localparam int CW = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] SLICE_LAST = CW'(SLICE_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

    logic [1:0]    state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0]    slice, slice_n;
    logic [2:0]    sel_n;
    logic [3:0]    bright_l, bright_n;
    logic          frame_done_n;
    logic          swap_en;
    logic          lit_n;
    frame_t        active;

    ssd_frame_buffer u_frame_buffer (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_valid (wr_valid),
        .wr_data  (wr_data),
        .wr_dp    (wr_dp),
        .wr_mask  (wr_mask),
        .swap_en  (swap_en),
        .wr_ready (wr_ready),
        .active   (active)
    );

    // Slot timing: BLANK counts whole cycles, SHOW counts
    // cycles within a PWM slice plus the slice index.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        slice_n  = slice;
        sel_n    = digit_sel;
        bright_n = bright_l;
        if (!enable) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
            slice_n = '0;
            sel_n   = '0;
        end else begin
            unique case (1'b1)
                (state == ST_IDLE): begin
                    state_n = ST_BLANK;
                    cnt_n   = '0;
                    slice_n = '0;
                    sel_n   = '0;
                end
                (state == ST_BLANK): begin
                    if (cnt == BLANK_LAST) begin
                        state_n  = ST_SHOW;
                        cnt_n    = '0;
                        slice_n  = '0;
                        bright_n = brightness;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                (state == ST_SHOW): begin
                    if (cnt == SLICE_LAST) begin
                        cnt_n = '0;
                        if (slice == 4'hF) begin
                            state_n = ST_BLANK;
                            slice_n = '0;
                            sel_n   = digit_sel + 3'd1;
                        end else begin
                            slice_n = slice + 4'd1;
                        end
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                    slice_n = '0;
                    sel_n   = '0;
                end
            endcase
        end
    end

    assign frame_done_n = (state_n == ST_SHOW) && (sel_n == 3'd7) &&
                          (slice_n == 4'hF) && (cnt_n == SLICE_LAST);

    assign lit_n = (state_n == ST_SHOW) && (slice_n <= bright_n) &&
                   active.mask[sel_n];

    // The swap edge is the one that raises frame_done, so the next
    // frame starts cleanly on the new buffer.
    assign swap_en = frame_done_n | (state == ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            slice      <= '0;
            digit_sel  <= '0;
            bright_l   <= '0;
            an         <= ANODES_OFF;
            digit_code <= '0;
            dp_out     <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            slice      <= slice_n;
            digit_sel  <= sel_n;
            bright_l   <= bright_n;
            an         <= lit_n ? ~(8'h01 << sel_n) : ANODES_OFF;
            digit_code <= nibble_at(active.data, sel_n);
            dp_out     <= active.dp[sel_n];
            frame_done <= frame_done_n;
        end
    end

endmodule

// File: tb/tb_ssd_scan_scheduler.sv
// Scoreboard bench: per-frame expectations are queued by the stimulus
// and checked by a monitor at each frame_done pulse.
module tb_ssd_scan_scheduler;

    localparam int DW = 32;
    localparam int BL = 4;
    localparam int PERIOD = 8 * (DW + BL);

    typedef struct packed {
        logic [7:0][7:0] low;
        logic [31:0]     code;
        logic [7:0]      dp;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [3:0]  brightness = 4'hF;
    logic        wr_valid = 1'b0;
    logic [31:0] wr_data = '0;
    logic [7:0]  wr_dp = '0;
    logic [7:0]  wr_mask = '0;
    logic        wr_ready;
    logic [7:0]  an;
    logic [3:0]  digit_code;
    logic        dp_out;
    logic [2:0]  digit_sel;
    logic        frame_done;

    int   n_vec = 0;
    int   n_err = 0;
    int   frames_seen = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    ssd_scan_scheduler #(
        .DWELL_CYCLES (DW),
        .BLANK_CYCLES (BL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .brightness (brightness),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_data    (wr_data),
        .wr_dp      (wr_dp),
        .wr_mask    (wr_mask),
        .an         (an),
        .digit_code (digit_code),
        .dp_out     (dp_out),
        .digit_sel  (digit_sel),
        .frame_done (frame_done)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input int lo, input logic [7:0] mask,
                                input logic [31:0] data,
                                input logic [7:0] dp);
        exp_t e;
        e = '0;
        for (int i = 0; i < 8; i++) begin
            if (mask[i]) begin
                e.low[i]        = 8'(lo);
                e.code[4*i +: 4] = data[4*i +: 4];
                e.dp[i]         = dp[i];
            end
        end
        return e;
    endfunction

    // Monitor: accumulate one frame of observations, compare at frame_done.
    int              cyc = 0;
    int              last_fd = 0;
    int              bad = 0;
    bit              hit;
    logic [7:0][7:0] lows;
    logic [31:0]     codes;
    logic [7:0]      dps;
    exp_t            me;

    always @(negedge clk) begin
        if (!rst_n || !enable) begin
            lows = '0;
            codes = '0;
            dps = '0;
            bad = 0;
            last_fd = cyc + 1;
        end else begin
            if (an != 8'hFF) begin
                hit = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    if (an == ~(8'h01 << i)) begin
                        hit = 1'b1;
                        if (lows[i] == 8'd0) begin
                            codes[4*i +: 4] = digit_code;
                            dps[i] = dp_out;
                            if (digit_sel != 3'(i)) bad++;
                        end
                        lows[i] = lows[i] + 8'd1;
                    end
                end
                if (!hit) bad++;
            end
            if (frame_done) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_frame: frame %0d had no expectation",
                             frames_seen + 1);
                end else begin
                    me = exp_q.pop_front();
                    chk($sformatf("f%0d_period", frames_seen + 1),
                        64'(cyc - last_fd), 64'(PERIOD));
                    chk($sformatf("f%0d_low_counts", frames_seen + 1),
                        lows, me.low);
                    chk($sformatf("f%0d_codes", frames_seen + 1),
                        codes, me.code);
                    chk($sformatf("f%0d_dps", frames_seen + 1),
                        dps, me.dp);
                    chk($sformatf("f%0d_bad_anode_or_sel", frames_seen + 1),
                        bad, 0);
                end
                frames_seen++;
                lows = '0;
                codes = '0;
                dps = '0;
                bad = 0;
                last_fd = cyc;
            end
        end
        cyc++;
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_frames(input int n);
        int k;
        k = 0;
        while (frames_seen < n && k < 3 * PERIOD) begin
            @(posedge clk);
            k++;
        end
        #1;
        if (frames_seen < n) chk("frame_timeout", frames_seen, n);
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic do_write(input logic [31:0] d, input logic [7:0] dp,
                            input logic [7:0] m, output int waited,
                            output logic fd_at_accept);
        wr_valid = 1'b1;
        wr_data = d;
        wr_dp = dp;
        wr_mask = m;
        waited = 0;
        @(negedge clk);
        while (!wr_ready && waited < 3 * PERIOD) begin
            @(negedge clk);
            waited++;
        end
        fd_at_accept = frame_done;
        if (!wr_ready) chk("write_timeout", wr_ready, 1);
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
    endtask

    initial begin
        int   bad1;
        int   w;
        logic fd;
        bit   done;

        repeat (3) @(negedge clk);
        chk("rst_an", an, 8'hFF);
        chk("rst_digit_code", digit_code, 0);
        chk("rst_dp_out", dp_out, 0);
        chk("rst_digit_sel", digit_sel, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_wr_ready", wr_ready, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        bad1 = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (an !== 8'hFF || wr_ready !== 1'b1 || frame_done !== 1'b0)
                bad1++;
        end
        chk("disabled_500_cycles", bad1, 0);
        cycles(1);

        exp_q.push_back(mk(32, 8'hFF, 32'h0, 8'h00));
        exp_q.push_back(mk(32, 8'hFF, 32'h0, 8'h00));
        enable = 1'b1;
        wait_frames(2);

        exp_q.push_back(mk(32, 8'hFF, 32'h0, 8'h00));
        exp_q.push_back(mk(32, 8'hFF, 32'h76543210, 8'h81));
        cycles(50);
        do_write(32'h76543210, 8'h81, 8'hFF, w, fd);
        chk("w1_accepted_at_once", w, 0);
        bad1 = 0;
        done = 1'b0;
        for (int i = 0; i < 3 * PERIOD && !done; i++) begin
            @(negedge clk);
            if (frame_done) begin
                done = 1'b1;
                chk("ready_at_swap", wr_ready, 1);
            end else if (wr_ready) begin
                bad1++;
            end
        end
        chk("swap_seen", done, 1);
        chk("ready_low_while_pending", bad1, 0);
        wait_frames(4);

        brightness = 4'd3;
        exp_q.push_back(mk(8, 8'hFF, 32'h76543210, 8'h81));
        cycles(20);
        do_write(32'hFEDCBA98, 8'h00, 8'h0F, w, fd);
        chk("w2_accepted_at_once", w, 0);
        exp_q.push_back(mk(8, 8'h0F, 32'hFEDCBA98, 8'h00));
        wait_frames(5);

        exp_q.push_back(mk(8, 8'hFF, 32'h33333333, 8'h00));
        exp_q.push_back(mk(8, 8'hFF, 32'hCCCCCCCC, 8'hFF));
        cycles(10);
        do_write(32'h33333333, 8'h00, 8'hFF, w, fd);
        chk("wa_accepted_at_once", w, 0);
        do_write(32'hCCCCCCCC, 8'hFF, 8'hFF, w, fd);
        chk("wb_accept_in_done_cycle", fd, 1);
        chk("wb_was_stalled", (w > 0), 1);
        wait_frames(8);

        cycles(7);
        @(negedge clk);
        chk("pre_drop_anode", an, 8'hFE);
        @(posedge clk);
        #1;
        enable = 1'b0;
        @(posedge clk);
        #1;
        chk("drop_an_off", an, 8'hFF);
        chk("drop_sel_zero", digit_sel, 0);
        chk("drop_no_done", frame_done, 0);
        brightness = 4'hF;
        cycles(10);
        exp_q.push_back(mk(32, 8'hFF, 32'hCCCCCCCC, 8'hFF));
        enable = 1'b1;
        wait_frames(9);

        cycles(30);
        do_write(32'h0, 8'h00, 8'hFF, w, fd);
        chk("pending_before_reset", wr_ready, 0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_an", an, 8'hFF);
        chk("async_rst_wr_ready", wr_ready, 1);
        chk("async_rst_sel", digit_sel, 0);
        chk("leftover_expectations", exp_q.size(), 0);
        enable = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ssd_scan_scheduler.md
Name: ssd_scan_scheduler

Overview:
Time-multiplexing scheduler for the 8-digit common-anode seven-segment display. It owns a double-buffered 32-bit frame (8 hex nibbles + decimal points + per-digit enable mask) written through a valid/ready port, and scans digits with a fixed dwell and an inter-digit blanking gap. It also applies 16-level brightness PWM. It outputs the active-low anode vector plus the current nibble/dp, which feed the existing hex-to-segment decoder.

Parameters:
DWELL_CYCLES, 100000, clocks per digit slot (1 ms at 100 MHz); must be a multiple of 16, minimum 16
BLANK_CYCLES, 2000, clocks all anodes off before each digit slot (anti-ghosting); minimum 1

Ports:
clk  in  1  system clock, 100 MHz
rst_n  in  1  asynchronous active-low reset
enable  in  1  scanning enable; 0 blanks display
brightness  in  4  PWM level, 0 = 1/16 duty, 15 = full
wr_valid  in  1  frame write request
wr_ready  out  1  shadow buffer free
wr_data  in  32  nibble i = wr_data[4i+3:4i] drives digit i
wr_dp  in  8  decimal point per digit
wr_mask  in  8  digit enable per digit
an  out  8  anode select, active-low, one-hot-low or all ones
digit_code  out  4  nibble of current digit
dp_out  out  1  dp of current digit
digit_sel  out  3  current digit index
frame_done  out  1  one-cycle pulse at end of digit 7 slot

Behaviour:
- Reset (async, rst_n=0): an=8'hFF, digit_code=0, dp_out=0, digit_sel=0, frame_done=0, wr_ready=1. Active buffer: data=0, dp=0, mask=8'hFF. Shadow empty. FSM=IDLE, counters 0.
- All outputs are registered and change on the clk edge that changes state/counters.
- FSM states:
  - IDLE: an=8'hFF. enable=1 -> BLANK with digit_sel=0.
  - BLANK: an=8'hFF for BLANK_CYCLES clocks, then -> SHOW.
  - SHOW: lasts DWELL_CYCLES clocks.
    - digit_code/dp_out come from the active buffer at digit_sel.
    - Slot is split into 16 slices of DWELL_CYCLES/16 clocks.
    - an[digit_sel]=0 during slice k iff k <= brightness_latched and mask[digit_sel]=1; otherwise an=8'hFF.
    - End of slot: digit_sel increments mod 8, -> BLANK.
- brightness is latched on BLANK->SHOW entry; changes mid-slot take effect next slot.
- Masked digits keep their full slot time (uniform frame period = 8*(BLANK_CYCLES+DWELL_CYCLES)) with anodes off.
- frame_done pulses on the last SHOW clock of digit 7.
- Write port:
  - Handshake on wr_valid & wr_ready: data, dp and mask are captured into the shadow buffer, pending=1.
  - wr_ready = ~pending.
  - Writes while pending are stalled, not dropped.
- Swap: pending shadow copies into the active buffer on the same edge as frame_done, or on any clock while in IDLE. pending clears on that edge. A swap never occurs mid-frame.
- Simultaneous swap and write request: wr_ready is 0 that cycle; the write is accepted on the next cycle.
- enable falls in any state: -> IDLE next edge; an=8'hFF, digit_sel=0, slot/slice counters cleared, no frame_done. Pending writes are preserved and swap while in IDLE.
- rst_n asserted mid-frame: immediate return to reset values; shadow contents are discarded.
- Counters are sized by $clog2 of the parameters and must not overflow at defaults.

Decomposition:
- Shared package/header: FSM state encoding (IDLE, BLANK, SHOW), NUM_DIGITS=8, ANODES_OFF=8'hFF, default timing constants.
- One natural sub-module, ssd_frame_buffer: shadow/active registers, pending flag, wr_ready, swap logic.
- FSM, timing counters and PWM stay in ssd_scan_scheduler.
- Segment decode remains in the existing seven_segment decoder, which is not duplicated here.

Test Plan:
Params DWELL_CYCLES=32, BLANK_CYCLES=4 for all scenarios below.
1. Reset release, enable=0 -> an=8'hFF, wr_ready=1, no frame_done for 500 clocks.
2. enable=1, brightness=15, default buffer -> an sequence FE,FD,FB,...,7F; each low for 32 clocks, separated by 4 clocks of FF; frame_done every 288 clocks; digit_code=0.
3. Write wr_data=32'h76543210, wr_dp=8'h81, wr_mask=8'hFF mid-frame -> wr_ready=0 until the next frame_done edge; following frame shows digit_code=i on digit i, dp_out=1 on digits 0 and 7.
4. brightness=3 -> per slot, anode low for exactly 8 clocks (slices 0-3 of 2 clocks), then FF for 24 clocks.
5. wr_mask=8'h0F -> digits 4-7 keep their 36-clock slots with an=FF; frame period unchanged at 288 clocks.
6. Two back-to-back writes (second held valid) -> second accepted the cycle after the first swap, displayed one frame later. enable dropped mid-SHOW -> an=FF next edge; re-enable restarts at digit 0.
